mod_add_sched: RTL

Round-robin scheduler that shares one `adder_pipe` modular-add pipeline among `N_REQ` requesters. It accepts operand pairs, stages them into the adder's two input channels, and records each issued op's requester index in an in-order tag FIFO. It routes each adder result back to the requester that issued it. It sits between the ZKP kernel's field-arithmetic clients and a single `adder_pipe` instance.

---
 rtl/mod_add_sched_pkg.sv | 20 ++
 rtl/tag_fifo.sv | 54 +++++
 rtl/mod_add_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mod_add_sched_pkg.sv
// rtl/mod_add_sched_pkg.sv - shared tag type and round-robin grant helper for mod_add_sched
package mod_add_sched_pkg;

    localparam int MAX_REQ   = 16;
    localparam int PKG_TAG_W = $clog2(MAX_REQ);

    typedef logic [PKG_TAG_W-1:0] tag_t;

    // Bits above the real requester count are zero, so wrapping at MAX_REQ
    // yields the same grant as wrapping at N_REQ.
    function automatic tag_t next_rr(input tag_t ptr, input logic [MAX_REQ-1:0] valid);
        tag_t idx;
        next_rr = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            idx = ptr + tag_t'(i);
            if (valid[idx]) next_rr = idx;
        end
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - synchronous first-word-fall-through FIFO holding requester tags
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mod_add_sched.sv
// rtl/mod_add_sched.sv - round-robin scheduler sharing one adder_pipe among N_REQ requesters
module mod_add_sched
    import mod_add_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int C_DATA_WIDTH = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int TAG_W        = $clog2(N_REQ),
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0][C_DATA_WIDTH-1:0]  req_a,
    input  logic [N_REQ-1:0][C_DATA_WIDTH-1:0]  req_b,
    output logic [N_REQ-1:0]                    req_ready,
    output logic [N_REQ-1:0]                    rsp_valid,
    output logic [C_DATA_WIDTH-1:0]             rsp_data,
    input  logic [N_REQ-1:0]                    rsp_ready,
    output logic [1:0]                          add_s_tvalid,
    output logic [1:0][C_DATA_WIDTH-1:0]        add_s_tdata,
    input  logic [1:0]                          add_s_tready,
    input  logic                                add_m_tvalid,
    input  logic [C_DATA_WIDTH-1:0]             add_m_tdata,
    output logic                                add_m_tready,
    output logic [CNT_W-1:0]                    inflight,
    output logic                                err_orphan
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(N_REQ - 1);

    logic                    stg_valid;
    logic [C_DATA_WIDTH-1:0] stg_a;
    logic [C_DATA_WIDTH-1:0] stg_b;
    logic [TAG_W-1:0]        stg_tag;
    logic [TAG_W-1:0]        rr_ptr;
    logic [TAG_W-1:0]        grant;
    logic [TAG_W-1:0]        head;
    logic [MAX_REQ-1:0]      valid_ext;
    logic                    issue;
    logic                    load;
    logic                    rsp_hs;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    unused_tready;

    assign unused_tready = add_s_tready[1] ^ fifo_full;

    always_comb begin
        valid_ext = '0;
        valid_ext[N_REQ-1:0] = req_valid;
    end

    assign grant = TAG_W'(next_rr(tag_t'(rr_ptr), valid_ext));
    assign issue = stg_valid && add_s_tready[0];
    // Credit is judged on the pre-update count, so a pop frees a slot only from the next cycle.
    assign load  = (!stg_valid || issue) && (inflight < CNT_MAX) && (|req_valid);

    always_comb begin
        req_ready = '0;
        if (load) req_ready[grant] = 1'b1;
    end

    assign add_s_tvalid   = {2{stg_valid}};
    assign add_s_tdata[0] = stg_a;
    assign add_s_tdata[1] = stg_b;

    always_comb begin
        rsp_valid = '0;
        if (add_m_tvalid && !fifo_empty) rsp_valid[head] = 1'b1;
    end

    assign add_m_tready = rsp_ready[head] && !fifo_empty;
    assign rsp_data     = add_m_tdata;
    assign rsp_hs       = add_m_tvalid && add_m_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            stg_valid <= 1'b0;
            stg_a     <= '0;
            stg_b     <= '0;
            stg_tag   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            stg_valid <= 1'b1;
            stg_a     <= req_a[grant];
            stg_b     <= req_b[grant];
            stg_tag   <= grant;
            rr_ptr    <= (grant == LAST_REQ) ? '0 : grant + TAG_W'(1);
        end else if (issue) begin
            stg_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            inflight   <= '0;
            err_orphan <= 1'b0;
        end else begin
            case ({load, rsp_hs})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            if (add_m_tvalid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .W     (TAG_W)
    ) u_tag_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (issue),
        .pop    (rsp_hs),
        .din    (stg_tag),
        .dout   (head),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

endmodule
